// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, NOP word and default widths for the fetch stage
package fetch_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_PC_INC = 1;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, UPDATE = 2'd2} fetch_state_t;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: next PC choice, priority live redirect > pending redirect > fetch_addr + PC_INC
// ports: redirect_valid/redirect_pc (live branch), pend_valid/pend_pc (stored branch),
//        fetch_addr (address just fetched), sel_pc (chosen next PC)
module next_pc_sel #(
  parameter int ADDR_W = 16,
  parameter int PC_INC = 1
) (
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_pc,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] sel_pc
);
  always_comb sel_pc = redirect_valid ? redirect_pc :
                       pend_valid     ? pend_pc     : fetch_addr + ADDR_W'(PC_INC);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multicycle IDLE/REQ/UPDATE instruction fetch with handshaked memory read
// ports: clk, reset (async active-low); pc, fetch_start; redirect_valid/redirect_pc;
//        mem_req/mem_addr/mem_ready/mem_rdata; next_pc/pc_write to program_counter;
//        instr/instr_valid; busy; fetch_err
// FETCH_TIMEOUT_EN: when defined, REQ aborts after TIMEOUT_CYCLES cycles without mem_ready
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_INC = DEF_PC_INC
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               fetch_start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               pc_write,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               fetch_err
);
  fetch_state_t state;
  logic [ADDR_W-1:0] fetch_addr, pend_pc, sel_pc;
  logic pend_valid;
`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic err;
`endif
  next_pc_sel #(.ADDR_W(ADDR_W), .PC_INC(PC_INC)) u_sel (
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pend_valid(pend_valid),
    .pend_pc(pend_pc),
    .fetch_addr(fetch_addr),
    .sel_pc(sel_pc)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fetch_addr <= '0;
      pend_valid <= 1'b0;
      pend_pc <= '0;
      instr <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt <= '0;
      err <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: if (fetch_start) begin
          fetch_addr <= pc;
          state <= REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        REQ: if (mem_ready) begin
          instr <= mem_rdata;
          state <= UPDATE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          err <= 1'b1;
          instr <= INSTR_W'(NOP_INSTR);
        end else cnt <= cnt + CNT_W'(1);
`endif
        UPDATE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // UPDATE consumes any stored target; elsewhere the latest redirect wins
      if (state == UPDATE) pend_valid <= 1'b0;
      else if (redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc <= redirect_pc;
      end
    end
  end
  // program_counter reloads every edge, so pass pc through except in UPDATE
  assign next_pc = state == UPDATE ? sel_pc : pc;
  assign pc_write = state == UPDATE;
  assign instr_valid = state == UPDATE;
  assign mem_req = state == REQ;
  assign mem_addr = fetch_addr;
  assign busy = state != IDLE;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err;
`else
  assign fetch_err = 1'b0;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Multicycle instruction-fetch stage. Sits between program_counter and instruction memory.
- Consumes the current `pc`, issues a handshaked memory read and latches the returned word into the instruction register.
- Drives `next_pc` back into program_counter: PC + PC_INC, or a branch/jump redirect target.
- Started by the control FSM; reports completion with a one-cycle valid pulse.

Parameters:
- ADDR_W, 16, PC and memory address width.
- INSTR_W, 16, instruction word width.
- PC_INC, 1, sequential PC increment (word-addressed memory).
- TIMEOUT_CYCLES, 16, max REQ cycles before abort (only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current PC from program_counter.
- fetch_start  in  1  control FSM request to fetch at `pc`.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  branch/jump target.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_W  read address.
- mem_ready  in  1  memory returns data this cycle.
- mem_rdata  in  INSTR_W  instruction data.
- next_pc  out  ADDR_W  value program_counter loads every clock edge.
- pc_write  out  1  high in the cycle `next_pc` differs from hold value.
- instr  out  INSTR_W  instruction register.
- instr_valid  out  1  one-cycle pulse when `instr` is updated.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  timeout pulse; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - state=IDLE; mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_write=0, busy=0, fetch_err=0.
  - Pending redirect cleared.
- Hold rule: program_counter has no enable, so outside UPDATE `next_pc = pc` (combinational passthrough). PC is therefore frozen except in UPDATE.
- FSM states: IDLE, REQ, UPDATE.
- IDLE:
  - fetch_start=1 -> capture `pc` into fetch_addr; go to REQ.
- REQ:
  - mem_req=1; mem_addr=fetch_addr, stable throughout REQ.
  - mem_ready=1 -> instr<=mem_rdata; go to UPDATE.
  - Otherwise stay in REQ.
- UPDATE (exactly one cycle):
  - instr_valid=1, pc_write=1.
  - next_pc = redirect_pc if redirect_valid=1 this cycle; else the stored pending target if set; else fetch_addr+PC_INC.
  - Pending redirect cleared; go to IDLE.
- Minimum latency:
  - fetch_start sampled at edge 0 -> REQ in cycle 1.
  - mem_ready in cycle 1 -> UPDATE in cycle 2.
  - New `pc` visible in cycle 3.
- Arithmetic: `fetch_addr+PC_INC` is modulo 2^ADDR_W, so 0xFFFF+1 -> 0x0000.
- Redirect capture: redirect_valid in IDLE or REQ stores redirect_pc as pending. A later redirect overwrites it (last wins).
- Ignored inputs:
  - fetch_start while busy is ignored and not queued.
  - mem_ready outside REQ is ignored.
- `instr` holds its value until the next successful fetch.
- Reset mid-REQ: mem_req deasserts immediately (asynchronously); no instr or PC update occurs.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - If TIMEOUT_CYCLES REQ cycles elapse without mem_ready: go to IDLE; pulse fetch_err for 1 cycle; instr<=NOP (0x0000); instr_valid=0; no PC update; pending redirect retained.
  - The counter clears on entry to REQ.
- Undefined: REQ waits indefinitely; fetch_err is constant 0; no counter logic.

Decomposition:
- fetch_pkg:
  - State enum (IDLE, REQ, UPDATE).
  - NOP_INSTR constant (16'h0000).
  - Default width constants.
- One natural sub-module, next_pc_sel: combinational incrementer plus the 3-way priority mux (live redirect > pending > sequential). Unit-testable alone.

Test Plan:
- Reset with pc=0x0000, then release reset -> all outputs 0, busy=0; next_pc tracks pc=0x0000.
- pc=0x0005, fetch_start pulse, mem_ready in first REQ cycle with rdata=0xA1B2 -> mem_addr=0x0005; instr=0xA1B2; instr_valid one cycle; next_pc=0x0006 in UPDATE; pc=0x0006 one cycle later.
- pc=0x0010, redirect_valid with redirect_pc=0x0040 during REQ, mem_ready delayed 3 cycles -> mem_req held 4 cycles with mem_addr stable at 0x0010; UPDATE next_pc=0x0040.
- pc=0xFFFF fetch -> next_pc=0x0000. Extra fetch_start during REQ is ignored: only one instr_valid pulse.
- Reset asserted during REQ -> mem_req drops without a clock edge. After release: IDLE, instr=0, no PC change.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready never asserted -> fetch_err pulse after 16 REQ cycles; instr=0x0000; pc unchanged.
